mem_port_arbiter: RTL and testbench

- Shares the single-port unified instruction/data memory between the fetch stage and the MEM-stage load/store path.
- Replaces the fixed alternate-phase slow-clock access scheme with a request/acknowledge arbiter.
- The pipeline stalls on missing acks instead of relying on a divided clock.
- Sits between the IF/MEM stages and the byte-addressable memory; data has priority, with a fetch anti-starvation limit.

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_arb_select.sv | 62 ++++++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Contents: FSM state enum, grant encoding, fetch access size, and a
// saturating 32-bit increment used by the optional performance counters.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_D    = 2'd2
  } arb_gnt_t;

  // Fetches are always full-word reads.
  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) begin
      sat_inc32 = value;
    end else begin
      sat_inc32 = value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Winner selection for the memory port arbiter.
// Data beats fetch unless the data side has already won MAX_DATA_STREAK
// times in a row while a fetch was waiting.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   if_req     : fetch request
//   d_req      : data request
//   grant      : strobe, a grant is taken at this edge
//   gnt        : combinational winner (GNT_NONE / GNT_IF / GNT_D)
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     if_req,
  input  logic     d_req,
  input  logic     grant,
  output arb_gnt_t gnt
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  logic [STREAK_W-1:0] streak_r;
  logic [STREAK_W-1:0] streak_nxt_s;

  // Winner: fetch only when data is absent or the data streak is exhausted.
  always_comb begin
    gnt = GNT_NONE;
    if (if_req && (!d_req || (streak_r == STREAK_MAX))) begin
      gnt = GNT_IF;
    end else if (d_req) begin
      gnt = GNT_D;
    end else begin
      gnt = GNT_NONE;
    end
  end

  // Streak grows only while a fetch is actually being held off.
  always_comb begin
    streak_nxt_s = streak_r;
    if (!grant) begin
      streak_nxt_s = streak_r;
    end else if ((gnt == GNT_D) && if_req) begin
      streak_nxt_s = (streak_r == STREAK_MAX) ? streak_r : streak_r + STREAK_W'(1);
    end else begin
      streak_nxt_s = '0;
    end
  end

  // Streak register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_r <= '0;
    end else begin
      streak_r <= streak_nxt_s;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Request/acknowledge arbiter sharing one single-port memory between the
// fetch stage and the load/store path. One transaction at a time: grant,
// one issue cycle (mem_en), MEM_LATENCY-1 wait cycles, then rdata capture
// and a one-cycle ack while the FSM is back in IDLE.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   if_req/if_addr/if_ack/if_rdata  : fetch side
//   d_req/d_we/d_addr/d_wdata/d_funct3/d_ack/d_rdata : data side
//   mem_en/mem_we/mem_addr/mem_wdata/mem_funct3/mem_rdata : memory side
//   busy                            : transaction in flight
// Optional build macro ARB_PERF_CNT_EN adds perf_if_wait and perf_d_grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = 9,
  parameter int DATA_W          = 32,
  parameter int MEM_LATENCY     = 1,
  parameter int MAX_DATA_STREAK = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_funct3,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_d_grants
`endif
);

  localparam int LAT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY);

  arb_state_t      state_r;
  arb_state_t      state_nxt_s;
  arb_gnt_t        gnt_s;
  logic            grant_s;
  logic            done_s;
  logic [LAT_W-1:0] lat_r;
  logic            store_r;

  // Arbitration is only open while idle, including the ack cycle.
  assign grant_s = (state_r == IDLE) && (if_req || d_req);
  assign busy    = (state_r != IDLE);

  mem_arb_select #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_select (
    .clk    (clk),
    .reset  (reset),
    .if_req (if_req),
    .d_req  (d_req),
    .grant  (grant_s),
    .gnt    (gnt_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; done_s marks the edge at which mem_rdata is valid.
  always_comb begin
    state_nxt_s = state_r;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_s && (gnt_s == GNT_IF)) begin
          state_nxt_s = BUSY_IF;
        end else if (grant_s && (gnt_s == GNT_D)) begin
          state_nxt_s = BUSY_D;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (lat_r == LAT_LAST) begin
          done_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Issue registers, latency counter, read data capture and ack pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_funct3 <= 3'b000;
      if_ack     <= 1'b0;
      if_rdata   <= '0;
      d_ack      <= 1'b0;
      d_rdata    <= '0;
      lat_r      <= '0;
      store_r    <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      if (state_r == IDLE) begin
        lat_r <= '0;
        if (grant_s && (gnt_s == GNT_IF)) begin
          mem_en     <= 1'b1;
          mem_addr   <= if_addr;
          mem_funct3 <= FUNCT3_WORD;
          store_r    <= 1'b0;
        end else if (grant_s && (gnt_s == GNT_D)) begin
          mem_en     <= 1'b1;
          mem_we     <= d_we;
          mem_addr   <= d_addr;
          mem_wdata  <= d_wdata;
          mem_funct3 <= d_funct3;
          store_r    <= d_we;
        end
      end else if (done_s) begin
        if (state_r == BUSY_IF) begin
          if_ack   <= 1'b1;
          if_rdata <= mem_rdata;
        end else begin
          d_ack <= 1'b1;
          // A store returns no data; keep the last load result.
          if (!store_r) begin
            d_rdata <= mem_rdata;
          end
        end
      end else begin
        lat_r <= lat_r + LAT_W'(1);
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  // Performance counters: fetch wait cycles and data grants.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_if_wait  <= 32'd0;
      perf_d_grants <= 32'd0;
    end else begin
      if (if_req && !(grant_s && (gnt_s == GNT_IF))) begin
        perf_if_wait <= sat_inc32(perf_if_wait);
      end
      if (grant_s && (gnt_s == GNT_D)) begin
        perf_d_grants <= sat_inc32(perf_d_grants);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MEM_LATENCY=1, MAX_DATA_STREAK=2).
// Directed vector table, hand-written starvation and reset sequences, then
// randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW   = 9;
  localparam int DW   = 32;
  localparam int ML   = 1;
  localparam int MAXS = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [2:0]    d_funct3;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_funct3;
  logic [DW-1:0] mem_rdata;
  logic          busy;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   perf_if_wait;
  logic [31:0]   perf_d_grants;
`endif

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(ML), .MAX_DATA_STREAK(MAXS)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_funct3(d_funct3), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata), .busy(busy)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_wait(perf_if_wait), .perf_d_grants(perf_d_grants)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, word-indexed, re-initialised on reset.
  logic [DW-1:0] mem [0:127];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      mem[4]    <= 32'h0050_0093;
      mem[8]    <= 32'hCAFE_F00D;
      mem[64]   <= 32'hDEAD_BEEF;
      mem_rdata <= 32'd0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[8:2]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[8:2]];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle.
  logic          e_en, e_we, e_busy, e_ia, e_da, c_ir, c_dr;
  logic [AW-1:0] e_addr;
  logic [2:0]    e_f3;
  logic [DW-1:0] e_wd, e_ir, e_dr;

  task automatic cmp_outputs(input string tag);
    chk({tag, ".mem_en"}, 32'(mem_en), 32'(e_en));
    chk({tag, ".mem_we"}, 32'(mem_we), 32'(e_we));
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(e_addr));
    chk({tag, ".mem_funct3"}, 32'(mem_funct3), 32'(e_f3));
    chk({tag, ".mem_wdata"}, mem_wdata, e_wd);
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".if_ack"}, 32'(if_ack), 32'(e_ia));
    chk({tag, ".d_ack"}, 32'(d_ack), 32'(e_da));
    if (c_ir) chk({tag, ".if_rdata"}, if_rdata, e_ir);
    if (c_dr) chk({tag, ".d_rdata"}, d_rdata, e_dr);
  endtask

  typedef struct {
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [2:0]    d_f3;
    logic          en, we;
    logic [AW-1:0] addr;
    logic [2:0]    f3;
    logic [DW-1:0] wd;
    logic          busy, ia, da, cir;
    logic [DW-1:0] ir;
    logic          cdr;
    logic [DW-1:0] dr;
  } vec_t;

  function automatic vec_t mk(
    input logic ir_q, input logic [AW-1:0] ia_q, input logic dq, input logic dw,
    input logic [AW-1:0] da_q, input logic [DW-1:0] dwd, input logic [2:0] df,
    input logic en, input logic we, input logic [AW-1:0] a, input logic [2:0] f3,
    input logic [DW-1:0] wd, input logic b, input logic ia, input logic da,
    input logic cir, input logic [DW-1:0] ir, input logic cdr, input logic [DW-1:0] dr);
    vec_t v;
    v.if_req = ir_q; v.if_addr = ia_q; v.d_req = dq; v.d_we = dw; v.d_addr = da_q;
    v.d_wdata = dwd; v.d_f3 = df; v.en = en; v.we = we; v.addr = a; v.f3 = f3;
    v.wd = wd; v.busy = b; v.ia = ia; v.da = da; v.cir = cir; v.ir = ir;
    v.cdr = cdr; v.dr = dr;
    return v;
  endfunction

  // Transaction-level reference model.
  int            m_left, m_streak;
  bit            m_is_if, m_store;
  logic [DW-1:0] m_data;
  int            m_if_wait, m_d_grants;

  task automatic model_reset();
    m_left = 0; m_streak = 0; m_if_wait = 0; m_d_grants = 0;
    e_en = 1'b0; e_we = 1'b0; e_busy = 1'b0; e_ia = 1'b0; e_da = 1'b0;
    e_addr = '0; e_f3 = 3'b000; e_wd = '0; e_ir = '0; e_dr = '0;
    c_ir = 1'b1; c_dr = 1'b1;
  endtask

  // Predict the outputs after the coming edge from the inputs now applied.
  task automatic model_step();
    bit fetch_wins;
    e_en = 1'b0; e_we = 1'b0; e_ia = 1'b0; e_da = 1'b0;
    fetch_wins = 1'b0;
    if (m_left == 0) begin
      if (if_req || d_req) begin
        fetch_wins = if_req && (!d_req || m_streak == MAXS);
        if (fetch_wins) begin
          m_streak = 0; m_is_if = 1'b1; m_store = 1'b0;
          e_addr = if_addr; e_f3 = 3'b010;
          m_data = mem[if_addr[8:2]];
        end else begin
          m_streak = if_req ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
          m_is_if = 1'b0; m_store = d_we;
          e_addr = d_addr; e_we = d_we; e_wd = d_wdata; e_f3 = d_funct3;
          m_data = mem[d_addr[8:2]];
          m_d_grants++;
        end
        e_en = 1'b1;
        m_left = ML + 1;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_is_if) begin
          e_ia = 1'b1; e_ir = m_data;
        end else begin
          e_da = 1'b1;
          if (!m_store) e_dr = m_data;
        end
      end
    end
    if (if_req && !fetch_wins) m_if_wait++;
    e_busy = (m_left != 0);
  endtask

  task automatic drive_idle();
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_funct3 = 3'b000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  vec_t vt[15];
  string kinds;
  int lat;

  initial begin
    vt[0]  = mk(1'b1, 9'h010, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b1, 1'b0, 9'h010, 3'b010, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    vt[1]  = mk(1'b1, 9'h010, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0, 1'b0, 9'h010, 3'b010, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    vt[2]  = mk(1'b1, 9'h010, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0, 1'b0, 9'h010, 3'b010, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0050_0093, 1'b0, 32'h0);
    vt[3]  = mk(1'b0, 9'h010, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0, 1'b0, 9'h010, 3'b010, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0050_0093, 1'b0, 32'h0);
    vt[4]  = mk(1'b1, 9'h020, 1'b1, 1'b0, 9'h100, 32'h0, 3'b010, 1'b1, 1'b0, 9'h100, 3'b010, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    vt[5]  = mk(1'b1, 9'h020, 1'b1, 1'b0, 9'h100, 32'h0, 3'b010, 1'b0, 1'b0, 9'h100, 3'b010, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    vt[6]  = mk(1'b1, 9'h020, 1'b1, 1'b0, 9'h100, 32'h0, 3'b010, 1'b0, 1'b0, 9'h100, 3'b010, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    vt[7]  = mk(1'b1, 9'h020, 1'b0, 1'b0, 9'h100, 32'h0, 3'b010, 1'b1, 1'b0, 9'h020, 3'b010, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    vt[8]  = mk(1'b1, 9'h020, 1'b0, 1'b0, 9'h100, 32'h0, 3'b010, 1'b0, 1'b0, 9'h020, 3'b010, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    vt[9]  = mk(1'b1, 9'h020, 1'b0, 1'b0, 9'h100, 32'h0, 3'b010, 1'b0, 1'b0, 9'h020, 3'b010, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0);
    vt[10] = mk(1'b0, 9'h020, 1'b0, 1'b0, 9'h100, 32'h0, 3'b010, 1'b0, 1'b0, 9'h020, 3'b010, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 32'hDEAD_BEEF);
    vt[11] = mk(1'b0, 9'h020, 1'b1, 1'b1, 9'h104, 32'h1234_5678, 3'b000, 1'b1, 1'b1, 9'h104, 3'b000, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    vt[12] = mk(1'b0, 9'h020, 1'b1, 1'b1, 9'h104, 32'h1234_5678, 3'b000, 1'b0, 1'b0, 9'h104, 3'b000, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    vt[13] = mk(1'b0, 9'h020, 1'b1, 1'b1, 9'h104, 32'h1234_5678, 3'b000, 1'b0, 1'b0, 9'h104, 3'b000, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    vt[14] = mk(1'b0, 9'h020, 1'b0, 1'b1, 9'h104, 32'h1234_5678, 3'b000, 1'b0, 1'b0, 9'h104, 3'b000, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 32'hDEAD_BEEF);

    // Reset state.
    do_reset();
    cmp_outputs("reset");

    // Directed vectors: lone fetch, data-vs-fetch contention, store.
    for (int i = 0; i < 15; i++) begin
      if_req = vt[i].if_req; if_addr = vt[i].if_addr; d_req = vt[i].d_req;
      d_we = vt[i].d_we; d_addr = vt[i].d_addr; d_wdata = vt[i].d_wdata;
      d_funct3 = vt[i].d_f3;
      @(posedge clk);
      #1;
      e_en = vt[i].en; e_we = vt[i].we; e_addr = vt[i].addr; e_f3 = vt[i].f3;
      e_wd = vt[i].wd; e_busy = vt[i].busy; e_ia = vt[i].ia; e_da = vt[i].da;
      c_ir = vt[i].cir; e_ir = vt[i].ir; c_dr = vt[i].cdr; e_dr = vt[i].dr;
      cmp_outputs($sformatf("vec%0d", i));
    end

    // Starvation: both requests held; issue order must be D D IF D D IF.
    if_req = 1'b1; if_addr = 9'h020; d_req = 1'b1; d_we = 1'b0;
    d_addr = 9'h100; d_funct3 = 3'b010;
    kinds = "";
    for (int c = 0; c < 18; c++) begin
      @(posedge clk);
      #1;
      if (mem_en) kinds = {kinds, (mem_addr == 9'h020) ? "I" : "D"};
    end
    checks++;
    if (kinds != "DDIDDI") begin
      errors++;
      $display("FAIL starve_order: got %s expected DDIDDI", kinds);
    end
    drive_idle();
    repeat (3) @(posedge clk);

    // Reset in the issue cycle of a fetch.
    #1;
    if_req = 1'b1; if_addr = 9'h010;
    @(posedge clk);
    #1;
    chk("abort.issue", 32'(mem_en), 32'd1);
    reset = 1'b1;
    if_req = 1'b0;
    #1;
    model_reset();
    cmp_outputs("abort.reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("abort.no_ack", 32'(if_ack), 32'd0);
    end
    if_req = 1'b1; if_addr = 9'h010;
    lat = 0;
    while (!if_ack && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
      if (if_ack) if_req = 1'b0;
    end
    if_req = 1'b0;
    chk("after_reset.latency", 32'(lat), 32'd3);
    chk("after_reset.if_rdata", if_rdata, 32'h0050_0093);
    @(posedge clk);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if_req   = ($urandom_range(0, 3) != 0);
      if_addr  = AW'($urandom);
      d_req    = ($urandom_range(0, 2) != 0);
      d_we     = $urandom_range(0, 1) == 1;
      d_addr   = AW'($urandom);
      d_wdata  = $urandom;
      d_funct3 = 3'($urandom);
      model_step();
      @(posedge clk);
      #1;
      cmp_outputs($sformatf("rand%0d", c));
    end
`ifdef ARB_PERF_CNT_EN
    chk("perf_if_wait", perf_if_wait, 32'(m_if_wait));
    chk("perf_d_grants", perf_d_grants, 32'(m_d_grants));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
